// File: rtl/md5_bf_job_ctrl_pkg.sv
// Shared types and widths for the MD5 brute-force job controller.
package md5_bf_pkg;

   localparam int MSG_W  = 512;
   localparam int HASH_W = 32;

   typedef enum logic [2:0] {IDLE, PRIME, RUN, FIN} ctrl_state_t;

   typedef enum logic [1:0] {ST_NONE, ST_FOUND, ST_EXHAUSTED, ST_TIMEOUT} job_status_t;

endpackage

// File: rtl/md5_bf_job_ctrl_if.sv
// Engine-side bus between the job controller (master) and the
// md5_brute_force_N_symb engine hierarchy (slave).
interface md5_bf_job_ctrl_if;
   import md5_bf_pkg::*;

   logic              bf_ce;
   logic              bf_reset;
   logic              bf_reset_zero_string;
   logic [MSG_W-1:0]  bf_start_str;
   logic [HASH_W-1:0] bf_a_hash;
   logic [HASH_W-1:0] bf_b_hash;
   logic [HASH_W-1:0] bf_c_hash;
   logic [HASH_W-1:0] bf_d_hash;
   logic              bf_find_str;
   logic              bf_symbols_done;
   logic [MSG_W-1:0]  bf_result_str;

   modport master (
      output bf_ce, bf_reset, bf_reset_zero_string, bf_start_str,
             bf_a_hash, bf_b_hash, bf_c_hash, bf_d_hash,
      input  bf_find_str, bf_symbols_done, bf_result_str
   );

   modport slave (
      input  bf_ce, bf_reset, bf_reset_zero_string, bf_start_str,
             bf_a_hash, bf_b_hash, bf_c_hash, bf_d_hash,
      output bf_find_str, bf_symbols_done, bf_result_str
   );

endinterface

// File: rtl/md5_bf_job_ctrl_watchdog.sv
// Saturating watchdog: counts enabled cycles, clears on request and flags
// the cycle on which the count reaches the limit.
module md5_bf_watchdog #(
   parameter int                WDOG_W     = 32,
   parameter logic [WDOG_W-1:0] WDOG_LIMIT = 32'h0100_0000
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic hit
);

   logic [WDOG_W-1:0] count;

   // Cycle counter: clear wins, then count up while enabled, holding at the limit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != WDOG_LIMIT)) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         count <= count + WDOG_W'(1);
      end
   end

   // Hit is raised in the cycle whose edge brings the count to the limit.
   assign hit = en && !clr && (count >= (WDOG_LIMIT - WDOG_W'(1)));

endmodule

// File: rtl/md5_bf_job_ctrl.sv
// Job-level master for the MD5 brute-force engine: accepts a job, primes and
// runs the engine, counts exhaustion pulses, captures the match, reports status.
module md5_bf_job_ctrl
   import md5_bf_pkg::*;
#(
   parameter int                RST_CYCLES = 4,
   parameter int                CNT_W      = 16,
   parameter int                WDOG_W     = 32,
   parameter logic [WDOG_W-1:0] WDOG_LIMIT = 32'h0100_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [MSG_W-1:0]  job_start_str,
   input  logic [HASH_W-1:0] job_hash_a,
   input  logic [HASH_W-1:0] job_hash_b,
   input  logic [HASH_W-1:0] job_hash_c,
   input  logic [HASH_W-1:0] job_hash_d,
   input  logic [CNT_W-1:0]  job_blocks,
   input  logic              abort,
   input  logic              done_ack,
   output logic              busy,
   output logic              done,
   output job_status_t       status,
   output logic [MSG_W-1:0]  result_str,
   output logic [CNT_W-1:0]  blocks_done,
   md5_bf_job_ctrl_if.master eng
);

   localparam int PRIME_W = $clog2(RST_CYCLES + 1);

   ctrl_state_t        state;
   ctrl_state_t        state_n;
   logic [PRIME_W-1:0] prime_cnt;
   logic [CNT_W-1:0]   job_blocks_q;
   logic [CNT_W-1:0]   blk_inc;
   logic               accept;
   logic               capture;
   logic               count_pulse;
   logic               go_fin;
   logic               ack;
   job_status_t        fin_status;
   logic               wdog_en;
   logic               wdog_clr;
   logic               wdog_hit;

   // Offer is taken whenever the controller is idle or parked in FIN.
   assign accept   = ((state == IDLE) || (state == FIN)) && job_valid && job_ready;
   assign blk_inc  = (&blocks_done) ? blocks_done : blocks_done + CNT_W'(1);
   assign wdog_en  = (state == RUN);
   assign wdog_clr = accept || ((state == RUN) && eng.bf_symbols_done);

   md5_bf_watchdog #(
      .WDOG_W     (WDOG_W),
      .WDOG_LIMIT (WDOG_LIMIT)
   ) u_wdog (
      .clk   (clk),
      .reset (reset),
      .en    (wdog_en),
      .clr   (wdog_clr),
      .hit   (wdog_hit)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Next state and event decode; abort > find > symbols_done > watchdog.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_n     = state;
      capture     = 1'b0;
      count_pulse = 1'b0;
      go_fin      = 1'b0;
      ack         = 1'b0;
      fin_status  = ST_NONE;
      case (state)
         IDLE, FIN: begin
            if (accept) begin
               state_n = PRIME;
            end else if ((state == FIN) && done_ack) begin
               ack     = 1'b1;
               state_n = IDLE;
            end
         end
         PRIME: begin
            if (abort)                                    state_n = IDLE;
            else if (prime_cnt == PRIME_W'(RST_CYCLES))   state_n = RUN;
         end
         RUN: begin
            if (abort) begin
               state_n = IDLE;
            end else begin
               count_pulse = eng.bf_symbols_done;
               if (eng.bf_find_str) begin
                  capture    = 1'b1;
                  go_fin     = 1'b1;
                  fin_status = ST_FOUND;
               end else if (eng.bf_symbols_done && (job_blocks_q != '0) &&
                            (blk_inc == job_blocks_q)) begin
                  go_fin     = 1'b1;
                  fin_status = ST_EXHAUSTED;
               end else if (wdog_hit) begin
                  go_fin     = 1'b1;
                  fin_status = ST_TIMEOUT;
               end
               if (go_fin) state_n = FIN;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Registered outputs and job datapath, all decoded from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the wide string and hash registers are reset too, so the
         // engine and the processor never observe stale data after reset.
         job_ready                <= 1'b1;
         busy                     <= 1'b0;
         done                     <= 1'b0;
         status                   <= ST_NONE;
         result_str               <= '0;
         blocks_done              <= '0;
         job_blocks_q             <= '0;
         prime_cnt                <= '0;
         eng.bf_ce                <= 1'b0;
         eng.bf_reset             <= 1'b1;
         eng.bf_reset_zero_string <= 1'b1;
         eng.bf_start_str         <= '0;
         eng.bf_a_hash            <= '0;
         eng.bf_b_hash            <= '0;
         eng.bf_c_hash            <= '0;
         eng.bf_d_hash            <= '0;
      end else begin
         job_ready                <= (state_n == IDLE) || (state_n == FIN);
         busy                     <= (state_n == PRIME) || (state_n == RUN);
         eng.bf_ce                <= (state_n == RUN);
         eng.bf_reset             <= (state_n != RUN);
         eng.bf_reset_zero_string <= (state_n != RUN);
         prime_cnt                <= (state == PRIME) ? prime_cnt + PRIME_W'(1) : '0;

         if (accept) begin
            eng.bf_start_str <= job_start_str;
            eng.bf_a_hash    <= job_hash_a;
            eng.bf_b_hash    <= job_hash_b;
            eng.bf_c_hash    <= job_hash_c;
            eng.bf_d_hash    <= job_hash_d;
            job_blocks_q     <= job_blocks;
            blocks_done      <= '0;
            status           <= ST_NONE;
            done             <= 1'b0;
         end
         if (count_pulse) blocks_done <= blk_inc;
         if (capture)     result_str  <= eng.bf_result_str;
         if (go_fin) begin
            status <= fin_status;
            done   <= 1'b1;
         end
         if (ack) begin
            status <= ST_NONE;
            done   <= 1'b0;
         end
      end
   end

endmodule

// File: doc/md5_bf_job_ctrl.md
Name: md5_bf_job_ctrl

Overview:
- Job-level master for the MD5 brute-force engine hierarchy. It is the initiator side of the engine's ce / reset / reset_zero_string / symbols_done / find_str interface.
- It accepts a job from the processor bridge: target hash, start string and iteration budget. It then resets and enables the engine, counts exhaustion pulses, and captures the matching string.
- Final status is reported back to the processor bridge.
- Sits between the processor register bank and the top md5_brute_force_N_symb instance.

Parameters:
- RST_CYCLES, 4: cycles bf_reset / bf_reset_zero_string are held high before enabling the engine (min 1).
- CNT_W, 16: width of the iteration budget and the symbols_done counter.
- WDOG_W, 32: width of the watchdog counter.
- WDOG_LIMIT, 32'h0100_0000: maximum cycles in RUN without a bf_symbols_done pulse before a timeout.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- job_valid, in, 1: job offer from the processor bridge.
- job_ready, out, 1: controller can accept a job.
- job_start_str, in, 512: initial message block.
- job_hash_a / job_hash_b / job_hash_c / job_hash_d, in, 32 each: target MD5 words.
- job_blocks, in, CNT_W: number of bf_symbols_done pulses allowed; 0 = unlimited.
- abort, in, 1: cancel the current job.
- done_ack, in, 1: clears done/status.
- busy, out, 1: job in progress.
- done, out, 1: sticky job-finished flag.
- status, out, 2: 0 none, 1 found, 2 exhausted, 3 timeout.
- result_str, out, 512: captured match.
- blocks_done, out, CNT_W: bf_symbols_done pulses counted in the current or last job.
- bf_ce, out, 1: engine enable.
- bf_reset, out, 1: engine reset (active-high).
- bf_reset_zero_string, out, 1: engine zero-string restart.
- bf_start_str, out, 512: registered copy of job_start_str.
- bf_a_hash / bf_b_hash / bf_c_hash / bf_d_hash, out, 32 each: registered hash words.
- bf_find_str, in, 1: engine match pulse.
- bf_symbols_done, in, 1: engine range-exhausted pulse.
- bf_result_str, in, 512: engine result, valid with bf_find_str.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - FSM to IDLE; job_ready=1.
  - busy, done, status, blocks_done, bf_ce to 0.
  - bf_reset=1, bf_reset_zero_string=1, so the engine is held reset.
  - result_str, bf_start_str and all bf hash words to 0.
- All outputs are registered.
- FSM states:
  - IDLE: job_ready=1, bf_ce=0, bf_reset=1.
    - On job_valid&&job_ready: latch start string, hash words and job_blocks; clear blocks_done, status, done and the watchdog; go to PRIME.
    - A job is accepted even while done=1; acceptance clears done.
  - PRIME: bf_reset=1, bf_reset_zero_string=1, bf_ce=0 for exactly RST_CYCLES cycles, then go to RUN. busy=1 from the cycle after acceptance.
  - RUN: bf_reset=0, bf_reset_zero_string=0, bf_ce=1. bf_ce first rises RST_CYCLES+1 cycles after the accept edge.
    - bf_find_str=1: capture bf_result_str into result_str, status=1, go to FIN.
    - bf_symbols_done=1: increment blocks_done. If job_blocks!=0 and the incremented value equals job_blocks, set status=2 and go to FIN. The watchdog clears on every pulse.
    - Watchdog reaches WDOG_LIMIT: status=3, go to FIN.
  - FIN: bf_ce=0, bf_reset=1, busy=0, done=1, job_ready=1.
    - done_ack clears done and status but keeps result_str and blocks_done; the FSM stays in IDLE-equivalent behaviour.
    - FIN and IDLE may be merged if all behaviour above is kept.
- Simultaneous events, highest priority first:
  1. reset.
  2. abort.
  3. bf_find_str.
  4. bf_symbols_done.
  5. watchdog.
- Abort in PRIME/RUN: go to IDLE next cycle; bf_ce=0, bf_reset=1, busy=0, done stays 0, status=0, result_str unchanged. Abort in IDLE/FIN has no effect.
- find_str and symbols_done in the same cycle: status=1 (found), but blocks_done still increments.
- Ignored inputs:
  - bf_find_str and bf_symbols_done outside RUN.
  - job_valid while busy (job_ready=0).
- blocks_done saturates at all-ones, no wrap; with job_blocks=0 the job ends only by find, timeout or abort.
- The watchdog counts only in RUN and saturates at WDOG_LIMIT.

Decomposition:
- Package md5_bf_pkg holds:
  - typedef enum logic [2:0] ctrl_state_t {IDLE, PRIME, RUN, FIN}.
  - typedef enum logic [1:0] job_status_t {ST_NONE, ST_FOUND, ST_EXHAUSTED, ST_TIMEOUT}.
  - localparam MSG_W = 512 and HASH_W = 32.
- One natural sub-module: md5_bf_watchdog (saturating counter with clear, enable and limit-hit output). Everything else stays flat.

Test Plan:
- Reset then idle:
  - Stimulus: reset=0 for 3 cycles, then release.
  - Response: job_ready=1, busy=0, bf_reset=1, bf_ce=0, status=0, result_str=0.
- Found:
  - Stimulus: job with job_blocks=5; engine model raises bf_find_str with bf_result_str=512'h...616263 after 2 symbols_done pulses.
  - Response: status=1, done=1, blocks_done=2, result_str equals the model value, bf_ce=0 next cycle.
- Exhausted:
  - Stimulus: job_blocks=3, no match, 3 symbols_done pulses.
  - Response: status=2 on the cycle after the third pulse; blocks_done=3.
- Timeout:
  - Stimulus: WDOG_LIMIT=100, engine silent.
  - Response: status=3, done=1, after 100 RUN cycles.
- Abort mid-RUN:
  - Stimulus: abort in RUN on the same cycle as bf_find_str.
  - Response: IDLE, done=0, status=0, result_str unchanged.
- Boundary:
  - Stimulus 1: RST_CYCLES=4. Response: bf_ce first rises exactly 5 cycles after accept.
  - Stimulus 2: job_blocks=0 with 10 symbols_done pulses. Response: still busy, blocks_done=10.
  - Stimulus 3: asynchronous reset asserted mid-RUN. Response: bf_ce drops immediately.
